// File: rtl/mapped_mem_ctrl.sv
// Memory-mapped controller: combinational instruction window onto an external ROM
// plus a wait-stated, byte-enabled data RAM with fault detection and counting.
module mapped_mem_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                IMEM_BYTES  = 400,
  parameter int                DMEM_BASE   = 0,
  parameter int                DMEM_WORDS  = 256,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] NOP_WORD    = 'h80000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [DATA_W-1:0]   instruction,
  output logic                ifetch_err,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] be,
  output logic                busy,
  output logic                ack,
  output logic [DATA_W-1:0]   rd,
  output logic                err,
  output logic [7:0]          err_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [ADDR_W:0] IMEM_X  = (ADDR_W+1)'(IMEM_BYTES);
  localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(DMEM_BASE);
  localparam logic [ADDR_W:0] LIMIT_X = (ADDR_W+1)'(DMEM_BASE + 4 * DMEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wd_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   mem [DMEM_WORDS];

  logic                in_imem;
  logic                fault_in;
  logic                acc_now;
  logic                acc_wait;
  logic                do_acc;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wd;
  logic [BE_W-1:0]     acc_be;
  logic [ADDR_W-1:0]   acc_off;
  logic [IDX_W-1:0]    acc_idx;

  assign in_imem     = ({1'b0, pc} < IMEM_X);
  assign rom_addr    = in_imem ? pc : '0;
  assign instruction = in_imem ? rom_data : NOP_WORD;
  assign ifetch_err  = ~in_imem;

  assign fault_in = ({1'b0, addr} < BASE_X) || ({1'b0, addr} >= LIMIT_X) || (addr[1:0] != 2'b00);

  // With no wait states the RAM is touched on the acceptance edge using the live inputs;
  // otherwise it happens on the last WAIT cycle from the captured copy.
  assign acc_now  = (state == IDLE) && req && !fault_in && (WAIT_STATES == 0);
  assign acc_wait = (state == WAIT) && (cnt == 3'd1);
  assign do_acc   = acc_now || acc_wait;
  assign acc_we   = (state == IDLE) ? we   : we_q;
  assign acc_addr = (state == IDLE) ? addr : addr_q;
  assign acc_wd   = (state == IDLE) ? wd   : wd_q;
  assign acc_be   = (state == IDLE) ? be   : be_q;
  assign acc_off  = acc_addr - BASE_X[ADDR_W-1:0];
  assign acc_idx  = acc_off[IDX_W+1:2];

  assign busy = (state != IDLE);
  assign ack  = (state == ACK);

  always_ff @(posedge clk) begin
    if (rst_n && do_acc && acc_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      be_q      <= '0;
      rd        <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
            be_q   <= be;
            if (fault_in) begin
              state <= ACK;
              err   <= 1'b1;
              rd    <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (WAIT_STATES == 0) begin
              state <= ACK;
              err   <= 1'b0;
              if (!we) rd <= mem[acc_idx];
            end else begin
              state <= WAIT;
              cnt   <= 3'(WAIT_STATES);
              err   <= 1'b0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ACK;
            if (!we_q) rd <= mem[acc_idx];
          end
        end
        ACK: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mapped_mem_ctrl.md
MAPPED_MEM_CTRL -- requirements
Module: mapped_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data and instruction word width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width of pc and addr.
REQ-003 SHALL have parameter IMEM_BYTES, default 400: size of the instruction window, starting at byte 0.
REQ-004 SHALL have parameter DMEM_BASE, default 0: byte base of the data window; word-aligned.
REQ-005 SHALL have parameter DMEM_WORDS, default 256: depth of the internal data RAM in words.
REQ-006 SHALL have parameter WAIT_STATES, default 1, range 0..7: extra cycles inserted before each data access.
REQ-007 SHALL have parameter NOP_WORD, default 32'h80000000: instruction returned for out-of-window fetches.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port pc, input, ADDR_W bits: instruction fetch byte address.
REQ-011 SHALL have port rom_addr, output, ADDR_W bits: address driven to the external instruction ROM.
REQ-012 SHALL have port rom_data, input, DATA_W bits: word returned by the external instruction ROM.
REQ-013 SHALL have port instruction, output, DATA_W bits: fetched instruction.
REQ-014 SHALL have port ifetch_err, output, 1 bit: pc lies outside the instruction window.
REQ-015 SHALL have port req, input, 1 bit: data access request.
REQ-016 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-017 SHALL have port addr, input, ADDR_W bits: data byte address.
REQ-018 SHALL have port wd, input, DATA_W bits: write data.
REQ-019 SHALL have port be, input, DATA_W/8 bits: byte enables.
REQ-020 SHALL have port busy, output, 1 bit: controller is not accepting requests.
REQ-021 SHALL have port ack, output, 1 bit: one-cycle access-complete pulse.
REQ-022 SHALL have port rd, output, DATA_W bits: read data.
REQ-023 SHALL have port err, output, 1 bit: access fault; qualified by ack.
REQ-024 SHALL have port err_count, output, 8 bits: saturating count of faulted accesses.

Function
REQ-025 Instruction path SHALL be combinational: if pc < IMEM_BYTES then rom_addr=pc, instruction=rom_data, ifetch_err=0; otherwise rom_addr=0, instruction=NOP_WORD, ifetch_err=1.
REQ-026 The data FSM SHALL have states IDLE, WAIT and ACK; busy=1 whenever the state is not IDLE.
REQ-027 In IDLE, req=1 SHALL accept the request and capture we, addr, wd and be.
REQ-028 Requests presented in WAIT or ACK SHALL be ignored and SHALL NOT be queued.
REQ-029 An accepted request SHALL fault when addr < DMEM_BASE, when addr >= DMEM_BASE+4*DMEM_WORDS, or when addr[1:0] != 0.
REQ-030 For a fault, the FSM SHALL go directly to ACK; ack=1, err=1 and rd=0 one cycle after acceptance, with no RAM write, regardless of WAIT_STATES.
REQ-031 For a valid request, the FSM SHALL go to WAIT with a counter loaded to WAIT_STATES.
REQ-032 The counter SHALL decrement each cycle; the RAM access SHALL occur on the edge where the counter is 0, and the FSM SHALL then go to ACK.
REQ-033 Valid-access latency SHALL be exactly WAIT_STATES+1 cycles from acceptance to ack.
REQ-034 The RAM word index SHALL be (addr-DMEM_BASE)>>2.
REQ-035 A write SHALL update only the bytes whose be bit is 1; be=0 SHALL complete with ack and no change.
REQ-036 ack SHALL be high for exactly one cycle (the ACK state), then the FSM SHALL return to IDLE.
REQ-037 Minimum request spacing SHALL be WAIT_STATES+2 cycles.
REQ-038 rd SHALL be registered: loaded with the RAM word on a valid read, with 0 on a fault, and held otherwise; writes SHALL leave rd unchanged.
REQ-039 err_count SHALL increment on each faulted access and saturate at 255.

Reset
REQ-040 rst_n=0 SHALL, at any time, force state=IDLE, counter=0, busy=0, ack=0, err=0, rd=0 and err_count=0.
REQ-041 A request interrupted by reset SHALL be discarded, and no RAM write SHALL occur after reset assertion.
REQ-042 RAM contents SHALL NOT be reset; reads of never-written words are undefined.
REQ-043 The instruction path SHALL be unaffected by rst_n.

Verification (WAIT_STATES=2, DMEM_BASE=0, DMEM_WORDS=256)
REQ-044 pc=396 -> instruction=rom_data, ifetch_err=0; pc=400 -> instruction=32'h80000000, ifetch_err=1, rom_addr=0.
REQ-045 Write addr=8, wd=32'hDEADBEEF, be=4'hF at cycle T; then read addr=8 -> ack at T+3 and, for the read, ack three cycles after acceptance with rd=32'hDEADBEEF.
REQ-046 Write addr=8, wd=32'h11223344, be=4'b0101; then read addr=8 -> rd=32'hDE22BE44.
REQ-047 Read addr=1024, then addr=6 -> each gives ack+err one cycle after acceptance, rd=0, err_count=2, and word 1 is unchanged.
REQ-048 req held high continuously -> accepted only in IDLE, acks spaced 4 cycles apart, busy=1 during WAIT and ACK.
REQ-049 rst_n pulled low during WAIT of a write to addr=12 -> no ack, a following read of addr=12 returns the prior value, and err_count=0.
